// File: rtl/stream_seq_pkg.sv
// stream_seq_pkg: shared state encoding and default widths for the stream FIFO sequencer.
package stream_seq_pkg;
  localparam int DIN_W_DEF  = 6;
  localparam int DOUT_W_DEF = 3;
  localparam int CNT_W_DEF  = 6;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } state_t;
endpackage

// File: rtl/axis_skid_buf.sv
// axis_skid_buf: 2-entry output buffer between FIFO read data and the stream port.
module axis_skid_buf #(
  parameter int DOUT_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DOUT_W-1:0] din,
  input  logic              pop,
  output logic [DOUT_W-1:0] dout,
  output logic              valid,
  output logic [1:0]        occ
);
  logic [DOUT_W-1:0] d0, d1;
  logic [1:0] cnt;
  assign dout  = d0;
  assign valid = cnt != 2'd0;
  assign occ   = cnt;
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      d0  <= '0;
      d1  <= '0;
    end else begin
      cnt <= cnt + {1'b0, push} - {1'b0, pop};
      if (push && (cnt == 2'd0 || (cnt == 2'd1 && pop))) d0 <= din;
      else if (pop && cnt == 2'd2) d0 <= d1;
      if (push && ((cnt == 2'd1 && !pop) || (cnt == 2'd2 && pop))) d1 <= din;
    end
  end
endmodule

// File: rtl/stream_fifo_sequencer.sv
// stream_fifo_sequencer: writes a counted burst into a FIFO and streams it back out as AXI-Stream beats.
// Optional SEQ_WR_ACK_CHECK_EN: count writes only on fifo_wr_ack and retry unacked writes.
module stream_fifo_sequencer
  import stream_seq_pkg::*;
#(
  parameter int DIN_W  = DIN_W_DEF,
  parameter int DOUT_W = DOUT_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [CNT_W-1:0]  cnt_limit,
  output logic [DIN_W-1:0]  fifo_din,
  output logic              fifo_wr_en,
  input  logic              fifo_full,
  input  logic              fifo_wr_ack,
  output logic              fifo_rd_en,
  input  logic [DOUT_W-1:0] fifo_dout,
  input  logic              fifo_empty,
  output logic [DOUT_W-1:0] m_axis_tdata,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic              m_axis_tlast,
  output logic              busy,
  output logic              done
);
  localparam int RATIO = DIN_W / DOUT_W;
  localparam int BC_W  = CNT_W + $clog2(RATIO) + 1;
  state_t state, state_nx;
  logic [CNT_W-1:0] lim, wc;
  logic [BC_W-1:0] bc, total;
  logic [1:0] occ;
  logic [2:0] used;
  logic rd_q, pop, active, wr_inc;
  assign active       = state == RUN || state == FLUSH;
  assign total        = BC_W'(lim) * BC_W'(RATIO);
  assign pop          = m_axis_tvalid && m_axis_tready;
  assign m_axis_tlast = m_axis_tvalid && bc == total - 1'b1;
  assign fifo_din     = DIN_W'(wc);
  assign busy         = state != IDLE;
  assign done         = state == DONE;
  // Occupancy left after this cycle's pop plus the read already in flight; keeps reads at one per cycle.
  assign used         = {1'b0, occ} + {2'b0, rd_q} - {2'b0, pop};
  assign fifo_rd_en   = active && !fifo_empty && used < 3'd2;
`ifdef SEQ_WR_ACK_CHECK_EN
  logic pend;
  assign fifo_wr_en = state == RUN && !fifo_full && wc < lim && !pend;
  assign wr_inc     = pend && fifo_wr_ack;
  always_ff @(posedge clk) pend <= rst ? 1'b0 : fifo_wr_en;
`else
  logic unused_ack;
  assign unused_ack = fifo_wr_ack;
  assign fifo_wr_en = state == RUN && !fifo_full && wc < lim;
  assign wr_inc     = fifo_wr_en;
`endif
  always_comb begin
    state_nx = state == IDLE  ? (start ? (cnt_limit == '0 ? DONE : RUN) : IDLE) :
               state == RUN   ? (wc == lim ? FLUSH : RUN) :
               state == FLUSH ? (pop && m_axis_tlast ? DONE : FLUSH) : IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      lim   <= '0;
      wc    <= '0;
      bc    <= '0;
      rd_q  <= 1'b0;
    end else begin
      state <= state_nx;
      rd_q  <= fifo_rd_en;
      if (pop) bc <= bc + 1'b1;
      if (wr_inc) wc <= wc + 1'b1;
      if (state == IDLE && start) begin
        lim <= cnt_limit;
        wc  <= '0;
        bc  <= '0;
      end
    end
  end
  axis_skid_buf #(.DOUT_W(DOUT_W)) u_buf (
    .clk   (clk),
    .rst   (rst),
    .push  (rd_q),
    .din   (fifo_dout),
    .pop   (pop),
    .dout  (m_axis_tdata),
    .valid (m_axis_tvalid),
    .occ   (occ)
  );
endmodule

// File: doc/stream_fifo_sequencer.md
STREAM_FIFO_SEQUENCER -- requirements
Module: stream_fifo_sequencer

Interface
REQ-001 The module SHALL have one clock, clk; reset is synchronous and active-high, named rst.
REQ-002 Parameter DIN_W, default 6, SHALL set the FIFO write width.
REQ-003 Parameter DOUT_W, default 3, SHALL set the FIFO read and stream width; DIN_W/DOUT_W (RATIO) SHALL be an integer >= 1.
REQ-004 Parameter CNT_W, default 6, SHALL set the transfer-count width.
REQ-005 Ports SHALL be:
- clk  in  1  clock
- rst  in  1  sync active-high reset
- start  in  1  start request, sampled in IDLE
- cnt_limit  in  CNT_W  number of FIFO writes per burst
- fifo_din  out  DIN_W  write data
- fifo_wr_en  out  1  write strobe
- fifo_full  in  1  FIFO full
- fifo_wr_ack  in  1  write accepted, one cycle after wr_en
- fifo_rd_en  out  1  read strobe
- fifo_dout  in  DOUT_W  read data, valid one cycle after rd_en
- fifo_empty  in  1  FIFO empty
- m_axis_tdata  out  DOUT_W  stream data
- m_axis_tvalid  out  1  stream valid
- m_axis_tready  in  1  stream ready
- m_axis_tlast  out  1  final beat of burst
- busy  out  1  high outside IDLE
- done  out  1  one-cycle pulse at burst end

Function
REQ-006 The FSM SHALL have states IDLE, RUN, FLUSH, DONE.
REQ-007 IDLE->RUN on start=1: latch cnt_limit into lim, clear write count wc and read-beat count bc; if cnt_limit==0, IDLE->DONE instead.
REQ-008 In RUN, fifo_wr_en SHALL be asserted when fifo_full==0 and wc<lim, with fifo_din = wc zero-extended to DIN_W; wc SHALL increment per accepted write.
REQ-009 fifo_wr_en SHALL never be asserted while fifo_full==1, including the post-reset full interval.
REQ-010 RUN->FLUSH when wc reaches lim; FLUSH->DONE when the beat with m_axis_tlast is accepted (tvalid&&tready); DONE->IDLE after one cycle with done=1.
REQ-011 The reader SHALL operate in RUN and FLUSH through a 2-entry output buffer; fifo_rd_en=1 when fifo_empty==0 and (buffered entries + reads in flight) < 2, giving sustained one beat per cycle.
REQ-012 Each FIFO read word SHALL be presented on m_axis_tdata unmodified and in read order; no beat SHALL be dropped or duplicated under any tready pattern.
REQ-013 tdata/tvalid/tlast SHALL be held stable while tvalid=1 and tready=0.
REQ-014 m_axis_tlast SHALL be 1 only on beat number lim*RATIO (bc width CNT_W+clog2(RATIO)+1).
REQ-015 start while busy==1 SHALL be ignored; cnt_limit SHALL only be sampled on the IDLE->RUN transition.
REQ-016 Simultaneous push into and pop from the output buffer in the same cycle SHALL keep occupancy unchanged.

Reset
REQ-017 On rst=1: state=IDLE, wc=0, bc=0, buffer empty, fifo_wr_en=0, fifo_rd_en=0, m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0, busy=0, done=0.
REQ-018 Reset mid-burst SHALL abort the burst with no done pulse; the FIFO shares rst and is flushed with it.

Configuration
REQ-019 With SEQ_WR_ACK_CHECK_EN defined, wc SHALL increment on fifo_wr_ack=1 and a write with no ack SHALL be retried with the same fifo_din; without it, wc SHALL increment on fifo_wr_en&&!fifo_full.

Structure
REQ-020 Package stream_seq_pkg SHALL hold the state enum and the default width constants.
REQ-021 The output buffer SHALL be a sub-module, axis_skid_buf, parameterised by DOUT_W.

Verification
REQ-022 cnt_limit=4, tready=1: writes 0,1,2,3; 8 beats; tlast on beat 8 only; done one cycle after that beat.
REQ-023 cnt_limit=0, start=1: busy high for 1 cycle, done pulses, no wr_en/rd_en/tvalid.
REQ-024 cnt_limit=20, tready toggling 1/0 per cycle: 40 beats in order matching the FIFO word order, stable while stalled, no loss.
REQ-025 FIFO full held 10 cycles mid-burst: wr_en=0 throughout, then writing resumes at the next wc value.
REQ-026 rst pulsed during RUN at wc=5: all outputs return to reset values next cycle, no done; a new start with cnt_limit=2 completes normally.
REQ-027 With SEQ_WR_ACK_CHECK_EN, wr_ack suppressed for write 3: the value 3 is re-issued and wc stays at 3 until it is acked.
